// File: rtl/serial_tofe_tx_if.sv
// Digit handshake and serial line bundle for serial_tofe_tx.
// Carries err_inject only when SERIAL_TOFE_TX_ERRINJ_EN is defined.
interface serial_tofe_tx_if;
    logic [3:0] din;
    logic       in_valid;
    logic       in_ready;
    logic       dout;
    logic       frame_start;
    logic       word_sent;
    logic       busy;
`ifdef SERIAL_TOFE_TX_ERRINJ_EN
    logic       err_inject;

    modport master (
        output din, in_valid, err_inject,
        input  in_ready, dout, frame_start, word_sent, busy
    );
    modport slave (
        input  din, in_valid, err_inject,
        output in_ready, dout, frame_start, word_sent, busy
    );
`else
    modport master (
        output din, in_valid,
        input  in_ready, dout, frame_start, word_sent, busy
    );
    modport slave (
        input  din, in_valid,
        output in_ready, dout, frame_start, word_sent, busy
    );
`endif
endinterface

// File: rtl/serial_tofe_tx.sv
// Serial 3-of-5 transmitter: BCD digits in, back-to-back 5-bit frames out, MSB first.
// Optional SERIAL_TOFE_TX_ERRINJ_EN adds err_inject, which flips the LSB of the encoded word.
//
// Handshake: a digit transfers on a rising edge where in_valid && in_ready;
// in_ready is high whenever the one-entry buffer is empty and resetL is high.
module serial_tofe_tx #(
    parameter logic [4:0] IDLE_WORD = 5'b00000
) (
    input logic            clk,
    input logic            resetL,
    serial_tofe_tx_if.slave bus
);

    localparam logic [2:0] LAST_BIT = 3'd4;

    logic [2:0] r_cnt;
    logic [4:0] r_shift;
    logic       r_buf_full;
    logic [3:0] r_buf_digit;
    logic       r_buf_inj;
    logic       r_carry;
    logic       r_dout;
    logic       r_frame_start;
    logic       r_word_sent;
    logic       r_busy;

    logic       w_inj;
    logic       w_in_ready;
    logic       w_xfer;
    logic       w_boundary;
    logic       w_sel_valid;
    logic [3:0] w_sel_digit;
    logic       w_sel_inj;
    logic       w_sel_legal;
    logic [4:0] w_new_word;

    function automatic logic [4:0] encode(input logic [3:0] digit);
        logic [4:0] word;
        case (digit)
            4'd0:    word = 5'b00111;
            4'd1:    word = 5'b01011;
            4'd2:    word = 5'b01101;
            4'd3:    word = 5'b01110;
            4'd4:    word = 5'b10011;
            4'd5:    word = 5'b10101;
            4'd6:    word = 5'b10110;
            4'd7:    word = 5'b11001;
            4'd8:    word = 5'b11010;
            4'd9:    word = 5'b11100;
            default: word = IDLE_WORD;
        endcase
        return word;
    endfunction

`ifdef SERIAL_TOFE_TX_ERRINJ_EN
    assign w_inj = bus.err_inject;
`else
    assign w_inj = 1'b0;
`endif

    assign w_in_ready = resetL & ~r_buf_full;
    assign w_xfer     = bus.in_valid & w_in_ready;
    assign w_boundary = (r_cnt == LAST_BIT);

    // Buffered digit wins; a same-edge transfer bypasses only into an empty buffer.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_digit = 4'd0;
        w_sel_inj   = 1'b0;
        if (r_buf_full) begin
            w_sel_valid = 1'b1;
            w_sel_digit = r_buf_digit;
            w_sel_inj   = r_buf_inj;
        end else if (w_xfer) begin
            w_sel_valid = 1'b1;
            w_sel_digit = bus.din;
            w_sel_inj   = w_inj;
        end
    end

    assign w_sel_legal = w_sel_valid && (w_sel_digit <= 4'd9);
    assign w_new_word  = w_sel_legal ? (encode(w_sel_digit) ^ {4'b0000, w_sel_inj})
                                     : IDLE_WORD;

    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL) begin
            r_cnt         <= LAST_BIT;
            r_shift       <= IDLE_WORD;
            r_buf_full    <= 1'b0;
            r_buf_digit   <= 4'd0;
            r_buf_inj     <= 1'b0;
            r_carry       <= 1'b0;
            r_dout        <= 1'b0;
            r_frame_start <= 1'b0;
            r_word_sent   <= 1'b0;
            r_busy        <= 1'b0;
        end else if (w_boundary) begin
            r_cnt         <= 3'd0;
            r_shift       <= {w_new_word[3:0], 1'b0};
            r_dout        <= w_new_word[4];
            r_frame_start <= 1'b1;
            r_word_sent   <= 1'b0;
            r_carry       <= w_sel_legal;
            r_buf_full    <= 1'b0;
            r_busy        <= w_sel_legal;
        end else begin
            r_cnt         <= r_cnt + 3'd1;
            r_shift       <= {r_shift[3:0], 1'b0};
            r_dout        <= r_shift[4];
            r_frame_start <= 1'b0;
            // Raised for the final bit of a digit frame only.
            r_word_sent   <= (r_cnt == 3'd3) && r_carry;
            r_busy        <= r_carry || r_buf_full || w_xfer;
            if (w_xfer) begin
                r_buf_full  <= 1'b1;
                r_buf_digit <= bus.din;
                r_buf_inj   <= w_inj;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.dout        = r_dout;
    assign bus.frame_start = r_frame_start;
    assign bus.word_sent   = r_word_sent;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_serial_tofe_tx.sv
// Randomized and directed bench for serial_tofe_tx against a frame-level reference model.
// Build with SERIAL_TOFE_TX_ERRINJ_EN defined to cover err_inject.
module tb_serial_tofe_tx;

    logic clk = 1'b0;
    logic resetL = 1'b0;

    serial_tofe_tx_if bus ();

    serial_tofe_tx dut (
        .clk    (clk),
        .resetL (resetL),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] enc_tab [10] = '{5'b00111, 5'b01011, 5'b01101, 5'b01110, 5'b10011,
                                 5'b10101, 5'b10110, 5'b11001, 5'b11010, 5'b11100};

    // Reference model: edge index since reset, pending digits, current frame.
    int         k = 0;
    logic [4:0] m_pend [$];
    logic [4:0] exp_q [$];
    logic [4:0] m_cur_word = 5'b0;
    logic       m_carry    = 1'b0;
    logic       m_cur_inj  = 1'b0;
    logic [4:0] m_obs      = 5'b0;
    logic       acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    // Called at a falling edge; drives one cycle, updates the model, checks, returns at next falling edge.
    task automatic step(input logic v, input logic [3:0] d, input logic inj, output logic accepted);
        logic       exp_ready;
        logic       has;
        logic [4:0] item;
        int         ph;
        bus.in_valid = v;
        bus.din      = d;
`ifdef SERIAL_TOFE_TX_ERRINJ_EN
        bus.err_inject = inj;
`endif
        #1;
        exp_ready = (m_pend.size() == 0);
        chk("in_ready", bus.in_ready, exp_ready);
        accepted = v && exp_ready;
        @(posedge clk);
        ph = k % 5;
        if (ph == 0) begin
            has  = 1'b0;
            item = 5'b0;
            if (m_pend.size() > 0) begin
                item = m_pend.pop_front();
                has  = 1'b1;
            end else if (accepted) begin
                item = {inj, d};
                has  = 1'b1;
            end
            m_carry    = has && (item[3:0] <= 4'd9);
            m_cur_inj  = item[4];
            m_cur_word = m_carry ? (enc_tab[item[3:0]] ^ {4'b0000, item[4]}) : 5'b00000;
            if (m_carry) exp_q.push_back(m_cur_word);
        end else if (accepted) begin
            m_pend.push_back({inj, d});
        end
        k++;
        #1;
        chk("dout", bus.dout, m_cur_word[4 - ph]);
        chk("frame_start", bus.frame_start, ph == 0);
        chk("word_sent", bus.word_sent, (ph == 4) && m_carry);
        chk("busy", bus.busy, m_carry || (m_pend.size() > 0));
        m_obs = {m_obs[3:0], bus.dout};
        if (ph == 4 && m_carry) begin
            if (exp_q.size() == 0)
                chk("exp_q_depth", exp_q.size(), 1);
            else
                chk("frame_word", m_obs, exp_q.pop_front());
            chk("rx_valid", $countones(m_obs) == 3, !m_cur_inj);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) step(1'b0, 4'd0, 1'b0, a);
    endtask

    task automatic send(input logic [3:0] d, input logic inj);
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, d, inj, acc);
            if (acc) break;
        end
        chk("send_accept", acc, 1'b1);
    endtask

    task automatic to_boundary();
        for (int i = 0; i < 5; i++) begin
            if (k % 5 == 0) break;
            idle(1);
        end
    endtask

    // Called at a falling edge; asserts reset, checks cleared outputs, releases on a later falling edge.
    task automatic apply_reset();
        resetL       = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_dout", bus.dout, 1'b0);
        chk("rst_frame_start", bus.frame_start, 1'b0);
        chk("rst_word_sent", bus.word_sent, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        resetL     = 1'b1;
        k          = 0;
        m_carry    = 1'b0;
        m_cur_word = 5'b0;
        m_cur_inj  = 1'b0;
        m_pend.delete();
        exp_q.delete();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.din      = 4'd0;
`ifdef SERIAL_TOFE_TX_ERRINJ_EN
        bus.err_inject = 1'b0;
`endif
        @(negedge clk);
        apply_reset();

        idle(15);

        to_boundary();
        send(4'd5, 1'b0);
        idle(5);

        to_boundary();
        for (int d = 0; d < 10; d++) send(4'(d), 1'b0);
        idle(10);

        to_boundary();
        send(4'd12, 1'b0);
        send(4'd3, 1'b0);
        idle(12);

        to_boundary();
        send(4'd9, 1'b0);
        send(4'd7, 1'b0);
        while (((k - 1) % 5) != 2) idle(1);
        apply_reset();
        idle(12);

`ifdef SERIAL_TOFE_TX_ERRINJ_EN
        to_boundary();
        send(4'd4, 1'b1);
        idle(6);
`endif

        for (int i = 0; i < 300; i++) begin
            logic       v;
            logic [3:0] d;
            logic       inj;
            v   = 1'($urandom_range(0, 1));
            d   = 4'($urandom_range(0, 15));
`ifdef SERIAL_TOFE_TX_ERRINJ_EN
            inj = 1'($urandom_range(0, 1));
`else
            inj = 1'b0;
`endif
            step(v, d, inj, acc);
            if (i == 150) apply_reset();
        end
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
